// File: rtl/axi_realigner_pkg.sv
// Shared types and helpers for the AXI-Stream byte realigner.
// Holds the realigner FSM states and the keep-count-to-mask conversion.
package axi_realigner_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  // Widest beat (in bytes) the mask helper can describe.
  localparam int MAX_DW = 64;

  // Contiguous-from-byte-0 mask with cnt ones; cnt == MAX_DW wraps to all ones.
  function automatic logic [MAX_DW-1:0] keep_mask(input logic [7:0] cnt);
    logic [MAX_DW-1:0] one;
    one = MAX_DW'(1);
    return (one << cnt) - one;
  endfunction

endpackage

// File: rtl/axi_realigner_if.sv
// AXI-Stream beat bundle used on both sides of the realigner.
// The master drives the payload; the slave returns tready.
interface axi_realigner_if #(
   parameter int DATA_WIDTH = 16
) ();

   logic                    tvalid;
   logic                    tready;
   logic                    tlast;
   logic [DATA_WIDTH*8-1:0] tdata;
   logic [DATA_WIDTH-1:0]   tkeep;

   modport master (
      output tvalid,
      output tlast,
      output tdata,
      output tkeep,
      input  tready
   );

   modport slave (
      input  tvalid,
      input  tlast,
      input  tdata,
      input  tkeep,
      output tready
   );

endinterface

// File: rtl/axi_byte_funnel.sv
// Combinational funnel shifter: selects DATA_WIDTH bytes starting at byte
// 'offset' out of the 2*DATA_WIDTH-byte window {new_beat, hold_beat}.
module axi_byte_funnel
   import axi_realigner_pkg::*;
#(
   parameter int DATA_WIDTH      = 16,
   parameter int SHIFT_VALUE_LEN = 4
) (
   input  logic [DATA_WIDTH*8-1:0]    new_beat,
   input  logic [DATA_WIDTH*8-1:0]    hold_beat,
   input  logic [SHIFT_VALUE_LEN-1:0] offset,
   output logic [DATA_WIDTH*8-1:0]    out_beat
);

   logic [2*DATA_WIDTH*8-1:0] window;

   // hold_beat is the older beat, so it sits in the low half of the window.
   assign window   = {new_beat, hold_beat} >> {offset, 3'b000};
   assign out_beat = window[DATA_WIDTH*8-1:0];

endmodule

// File: rtl/axi_realigner.sv
// AXI-Stream realigner: moves the byte at the packet's first-beat offset to
// byte 0 of the output and packs all following bytes contiguously behind it.
module axi_realigner
   import axi_realigner_pkg::*;
#(
   parameter int DATA_WIDTH      = 16,
   parameter int SHIFT_VALUE_LEN = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   axi_realigner_if.slave             s,
   input  logic [SHIFT_VALUE_LEN-1:0] s_offset,
   axi_realigner_if.master            m,
   output logic                       err,
   output state_t                     dbg_state
);

   localparam int DW = DATA_WIDTH;
   localparam int BW = DATA_WIDTH * 8;
   localparam int CW = SHIFT_VALUE_LEN + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DATA_WIDTH);

   state_t                     state;
   logic [BW-1:0]              hold_q;
   logic [SHIFT_VALUE_LEN-1:0] off_q;
   logic [CW-1:0]              last_n_q;
   logic                       out_valid_q;
   logic                       out_last_q;
   logic [DW-1:0]              out_keep_q;
   logic [BW-1:0]              out_data_q;
   logic                       err_q;

   logic                       out_ready;
   logic                       s_ready;
   logic                       accept;
   logic                       load;
   logic [CW-1:0]              n_in;
   logic [CW-1:0]              off_ext;
   logic [CW-1:0]              s_off_ext;
   logic [CW-1:0]              cand_cnt;
   logic                       cand_last;
   logic [DW-1:0]              cand_keep;
   logic [BW-1:0]              cand_data;
   logic [BW-1:0]              fun_new;
   logic [BW-1:0]              fun_hold;
   logic [BW-1:0]              fun_out;
   logic [SHIFT_VALUE_LEN-1:0] fun_off;

   // Handshake: a beat moves on either side exactly on a rising edge where
   // valid and ready are both 1. s.tready depends only on state, reset and the
   // output register (empty, or draining this cycle), never on s.tvalid, and it
   // is forced low in FLUSH while the residual beat is emitted.
   assign out_ready = !out_valid_q || m.tready;
   assign s_ready   = rst_n && (state != FLUSH) && out_ready;
   assign accept    = s.tvalid && s_ready;

   assign n_in      = CW'($countones(s.tkeep));
   assign off_ext   = {1'b0, off_q};
   assign s_off_ext = {1'b0, s_offset};

   // Candidate output beat for the current state, before the load decision.
   always_comb begin
      fun_new   = s.tdata;
      fun_hold  = hold_q;
      fun_off   = off_q;
      cand_cnt  = FULL_CNT;
      cand_last = 1'b0;
      case (state)
         IDLE: begin
            fun_new   = '0;
            fun_hold  = s.tdata;
            fun_off   = s_offset;
            cand_cnt  = n_in - s_off_ext;
            cand_last = 1'b1;
         end
         STREAM: begin
            if (s.tlast && (n_in <= off_ext)) begin
               cand_cnt  = FULL_CNT - off_ext + n_in;
               cand_last = 1'b1;
            end
         end
         FLUSH: begin
            fun_new   = '0;
            cand_cnt  = last_n_q - off_ext;
            cand_last = 1'b1;
         end
         default: ;
      endcase
   end

   axi_byte_funnel #(
      .DATA_WIDTH      (DATA_WIDTH),
      .SHIFT_VALUE_LEN (SHIFT_VALUE_LEN)
   ) u_funnel (
      .new_beat  (fun_new),
      .hold_beat (fun_hold),
      .offset    (fun_off),
      .out_beat  (fun_out)
   );

   // Bytes beyond the keep count are zeroed so stale hold bytes never leak out.
   always_comb begin
      cand_keep = DW'(keep_mask(8'(cand_cnt)));
      cand_data = '0;
      for (int i = 0; i < DW; i++) begin
         cand_data[8*i +: 8] = fun_out[8*i +: 8] & {8{cand_keep[i]}};
      end
   end

   assign load = (accept && (state == STREAM)) ||
                 (accept && (state == IDLE) && s.tlast && (n_in > s_off_ext)) ||
                 ((state == FLUSH) && out_ready);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         hold_q      <= '0;
         off_q       <= '0;
         last_n_q    <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_keep_q  <= '0;
         out_data_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         if (out_valid_q && m.tready) begin
            out_valid_q <= 1'b0;
         end
         if (load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= cand_data;
            out_keep_q  <= cand_keep;
            out_last_q  <= cand_last;
         end
         case (state)
            IDLE: begin
               if (accept) begin
                  if (!s.tlast) begin
                     hold_q <= s.tdata;
                     off_q  <= s_offset;
                     state  <= STREAM;
                  end else if (n_in <= s_off_ext) begin
                     // Single-beat packet with no byte at or after the offset.
                     err_q <= 1'b1;
                  end
               end
            end
            STREAM: begin
               if (accept) begin
                  hold_q <= s.tdata;
                  if (s.tlast) begin
                     if (cand_last) begin
                        state <= IDLE;
                     end else begin
                        last_n_q <= n_in;
                        state    <= FLUSH;
                     end
                  end
               end
            end
            FLUSH: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign m.tvalid  = out_valid_q;
   assign m.tlast   = out_last_q;
   assign m.tkeep   = out_keep_q;
   assign m.tdata   = out_data_q;
   assign s.tready  = s_ready;
   assign err       = err_q;
   assign dbg_state = state;

endmodule

// File: tb/tb_axi_realigner.sv
// Directed and randomized bench for axi_realigner (16-byte beats).
// Tasks drive packets, a sink records output beats, each test checks inline.
module tb_axi_realigner;
  import axi_realigner_pkg::*;

  localparam int DW = 16;
  localparam int BW = DW * 8;
  localparam int EW = BW + DW + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] s_offset;
  logic       err;
  state_t     dbg_state;

  axi_realigner_if #(.DATA_WIDTH(DW)) sif ();
  axi_realigner_if #(.DATA_WIDTH(DW)) mif ();

  axi_realigner #(
    .DATA_WIDTH      (DW),
    .SHIFT_VALUE_LEN (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s         (sif),
    .s_offset  (s_offset),
    .m         (mif),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int vectors = 0;
  int miscompares = 0;
  int unstable = 0;
  int want = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] got_q[$];
  int got_cyc_q[$];
  int acc_cyc_q[$];

  // Bytes numbered start, start+1, ... in byte lanes 0..cnt-1, rest zero.
  function automatic logic [BW-1:0] pat(input int start, input int cnt);
    logic [BW-1:0] d;
    d = '0;
    for (int j = 0; j < cnt; j++) d[8*j +: 8] = 8'(start + j);
    return d;
  endfunction

  function automatic logic [DW-1:0] kmask(input int cnt);
    logic [DW:0] t;
    t = (17'd1 << cnt) - 17'd1;
    return t[DW-1:0];
  endfunction

  // ---------------- driver tasks ----------------
  // Entered at a negedge; returns at the negedge after the beat is accepted.
  task automatic drive_beat(input logic [BW-1:0] d, input logic [DW-1:0] k,
                            input logic l, input logic [3:0] off);
    bit acc;
    int guard;
    acc = 1'b0;
    guard = 0;
    sif.tvalid = 1'b1;
    sif.tdata  = d;
    sif.tkeep  = k;
    sif.tlast  = l;
    s_offset   = off;
    while (!acc && guard < 500) begin
      #1;
      acc = sif.tready;
      @(negedge clk);
      guard++;
    end
    vectors++;
    if (acc) acc_cyc_q.push_back(cyc);
    else begin
      miscompares++;
      $display("FAIL drive_timeout got=no_accept exp=accept within 500 cycles");
    end
    sif.tvalid = 1'b0;
  endtask

  // Builds the beats, appends the byte-stream model's expected output to exp_q,
  // then drives the beats. rnd selects random data / don't-care fields.
  task automatic send_pkt(input int off, input int nb, input int n, input bit rnd);
    logic [BW-1:0] bt[4];
    logic [7:0]    bq[$];
    logic [BW-1:0] d;
    logic [DW-1:0] k;
    int lo, hi, cnt;
    for (int b = 0; b < nb; b++)
      bt[b] = rnd ? {$urandom, $urandom, $urandom, $urandom} : pat(b * 16, 16);
    for (int b = 0; b < nb; b++) begin
      lo = (b == 0) ? off : 0;
      hi = (b == nb - 1) ? n : 16;
      for (int i = lo; i < hi; i++) bq.push_back(bt[b][8*i +: 8]);
    end
    while (bq.size() > 0) begin
      d = '0;
      cnt = (bq.size() > 16) ? 16 : bq.size();
      for (int j = 0; j < cnt; j++) d[8*j +: 8] = bq.pop_front();
      exp_q.push_back({(bq.size() == 0), kmask(cnt), d});
    end
    for (int b = 0; b < nb; b++) begin
      if (b == nb - 1) k = kmask(n);
      else k = rnd ? 16'($urandom) : 16'hFFFF;
      drive_beat(bt[b], k, (b == nb - 1),
                 (b == 0 || !rnd) ? 4'(off) : 4'($urandom));
    end
  endtask

  // Output sink: drives m.tready and records every transferred beat until
  // 'want' beats are in got_q or max_cyc cycles pass.
  task automatic collect(input int max_cyc, input bit stall);
    int guard;
    bit prev_stalled;
    logic [EW-1:0] prev, cur;
    guard = 0;
    prev_stalled = 1'b0;
    prev = '0;
    while (got_q.size() < want && guard < max_cyc) begin
      @(negedge clk);
      mif.tready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #2;
      cur = {mif.tlast, mif.tkeep, mif.tdata};
      if (prev_stalled && (!mif.tvalid || cur !== prev)) unstable++;
      prev_stalled = mif.tvalid && !mif.tready;
      prev = cur;
      if (mif.tvalid && mif.tready) begin
        got_q.push_back(cur);
        got_cyc_q.push_back(cyc);
      end
      guard++;
    end
    mif.tready = 1'b1;
  endtask

  task automatic clear_sb();
    exp_q.delete();
    got_q.delete();
    got_cyc_q.delete();
    acc_cyc_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    sif.tvalid = 1'b0;
    sif.tlast = 1'b0;
    sif.tdata = '0;
    sif.tkeep = '0;
    s_offset = '0;
    mif.tready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if ({mif.tvalid, mif.tlast, err, sif.tready} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ctrl got=%b exp=0000", {mif.tvalid, mif.tlast, err, sif.tready});
    end
    vectors++;
    if (mif.tkeep !== 16'h0 || mif.tdata !== '0) begin
      miscompares++;
      $display("FAIL reset_data got keep=%h data=%h exp=0", mif.tkeep, mif.tdata);
    end
    vectors++;
    if (dbg_state !== IDLE) begin
      miscompares++;
      $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE);
    end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    vectors++;
    if (sif.tready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready got=%b exp=1", sif.tready);
    end
  endtask

  task automatic test_passthrough();
    logic [EW-1:0] e;
    @(negedge clk);
    clear_sb();
    want = 3;
    fork
      send_pkt(0, 3, 8, 1'b0);
      collect(100, 1'b0);
    join
    vectors++;
    if (got_q.size() !== 3) begin
      miscompares++;
      $display("FAIL pt_count got=%0d exp=3", got_q.size());
    end
    while (got_q.size() < 3) got_q.push_back('x);
    while (got_cyc_q.size() < 2) got_cyc_q.push_back(-1);
    while (acc_cyc_q.size() < 2) acc_cyc_q.push_back(-2);
    for (int i = 0; i < 3; i++) begin
      e = (i < 2) ? {1'b0, 16'hFFFF, pat(16 * i, 16)} : {1'b1, 16'h00FF, pat(32, 8)};
      vectors++;
      if (got_q[i] !== e) begin
        miscompares++;
        $display("FAIL pt_beat%0d got=%h exp=%h", i, got_q[i], e);
      end
    end
    vectors++;
    if (got_cyc_q[0] !== acc_cyc_q[1]) begin
      miscompares++;
      $display("FAIL pt_latency got=cycle %0d exp=cycle %0d", got_cyc_q[0], acc_cyc_q[1]);
    end
    vectors++;
    if (got_cyc_q[1] !== got_cyc_q[0] + 1) begin
      miscompares++;
      $display("FAIL pt_throughput got=cycle %0d exp=cycle %0d", got_cyc_q[1], got_cyc_q[0] + 1);
    end
  endtask

  task automatic test_short_tail();
    logic [EW-1:0] e;
    @(negedge clk);
    clear_sb();
    want = 1;
    fork
      send_pkt(5, 2, 3, 1'b0);
      collect(100, 1'b0);
    join
    vectors++;
    if (got_q.size() !== 1) begin
      miscompares++;
      $display("FAIL tail_count got=%0d exp=1", got_q.size());
    end
    while (got_q.size() < 1) got_q.push_back('x);
    e = {1'b1, 16'h3FFF, pat(5, 14)};
    vectors++;
    if (got_q[0] !== e) begin
      miscompares++;
      $display("FAIL tail_beat got=%h exp=%h", got_q[0], e);
    end
  endtask

  task automatic test_flush();
    logic [EW-1:0] e;
    @(negedge clk);
    clear_sb();
    want = 2;
    fork
      begin
        send_pkt(5, 2, 10, 1'b0);
        #1;
        vectors++;
        if (sif.tready !== 1'b0 || dbg_state !== FLUSH) begin
          miscompares++;
          $display("FAIL flush_ready got=ready %b state %0d exp=ready 0 state %0d",
                   sif.tready, dbg_state, FLUSH);
        end
      end
      collect(100, 1'b0);
    join
    vectors++;
    if (got_q.size() !== 2) begin
      miscompares++;
      $display("FAIL flush_count got=%0d exp=2", got_q.size());
    end
    while (got_q.size() < 2) got_q.push_back('x);
    for (int i = 0; i < 2; i++) begin
      e = (i == 0) ? {1'b0, 16'hFFFF, pat(5, 16)} : {1'b1, 16'h001F, pat(21, 5)};
      vectors++;
      if (got_q[i] !== e) begin
        miscompares++;
        $display("FAIL flush_beat%0d got=%h exp=%h", i, got_q[i], e);
      end
    end
  endtask

  task automatic test_error();
    logic [EW-1:0] e;
    @(negedge clk);
    clear_sb();
    send_pkt(3, 1, 2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (mif.tvalid !== 1'b0 || dbg_state !== IDLE) begin
        miscompares++;
        $display("FAIL err_no_output got=valid %b state %0d exp=valid 0 state %0d",
                 mif.tvalid, dbg_state, IDLE);
      end
      @(negedge clk);
    end
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_flag got=%b exp=1", err);
    end
    clear_sb();
    want = 1;
    fork
      send_pkt(0, 1, 4, 1'b0);
      collect(100, 1'b0);
    join
    while (got_q.size() < 1) got_q.push_back('x);
    e = {1'b1, 16'h000F, pat(0, 4)};
    vectors++;
    if (got_q[0] !== e) begin
      miscompares++;
      $display("FAIL err_next_pkt got=%h exp=%h", got_q[0], e);
    end
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_sticky got=%b exp=1", err);
    end
  endtask

  task automatic test_mid_reset();
    logic [EW-1:0] e;
    @(negedge clk);
    clear_sb();
    mif.tready = 1'b0;
    drive_beat(pat(0, 16), 16'hFFFF, 1'b0, 4'd7);
    drive_beat(pat(16, 16), 16'hFFFF, 1'b0, 4'd7);
    #1;
    vectors++;
    if (mif.tvalid !== 1'b1 || dbg_state !== STREAM) begin
      miscompares++;
      $display("FAIL mrst_pre got=valid %b state %0d exp=valid 1 state %0d",
               mif.tvalid, dbg_state, STREAM);
    end
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    vectors++;
    if ({mif.tvalid, mif.tlast, err, sif.tready} !== 4'b0000 ||
        mif.tkeep !== 16'h0 || mif.tdata !== '0 || dbg_state !== IDLE) begin
      miscompares++;
      $display("FAIL mrst_outputs got=ctrl %b keep %h data %h state %0d exp=all zero, IDLE",
               {mif.tvalid, mif.tlast, err, sif.tready}, mif.tkeep, mif.tdata, dbg_state);
    end
    rst_n = 1'b1;
    mif.tready = 1'b1;
    @(negedge clk);
    clear_sb();
    want = 2;
    fork
      send_pkt(2, 2, 4, 1'b0);
      collect(100, 1'b0);
    join
    vectors++;
    if (got_q.size() !== 2) begin
      miscompares++;
      $display("FAIL mrst_count got=%0d exp=2", got_q.size());
    end
    while (got_q.size() < 2) got_q.push_back('x);
    for (int i = 0; i < 2; i++) begin
      e = (i == 0) ? {1'b0, 16'hFFFF, pat(2, 16)} : {1'b1, 16'h0003, pat(18, 2)};
      vectors++;
      if (got_q[i] !== e) begin
        miscompares++;
        $display("FAIL mrst_beat%0d got=%h exp=%h", i, got_q[i], e);
      end
    end
  endtask

  task automatic test_random();
    @(negedge clk);
    clear_sb();
    unstable = 0;
    want = 1000000;
    fork
      begin
        for (int p = 0; p < 100; p++) begin
          int off, nb, n;
          off = $urandom_range(0, 15);
          nb  = $urandom_range(1, 4);
          n   = $urandom_range(1, 16);
          if (nb == 1 && n <= off) n = $urandom_range(off + 1, 16);
          send_pkt(off, nb, n, 1'b1);
          repeat ($urandom_range(0, 1)) @(negedge clk);
        end
        want = exp_q.size();
      end
      collect(20000, 1'b1);
    join
    vectors++;
    if (got_q.size() !== exp_q.size()) begin
      miscompares++;
      $display("FAIL rnd_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    while (got_q.size() < exp_q.size()) got_q.push_back('x);
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL rnd_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (unstable !== 0) begin
      miscompares++;
      $display("FAIL rnd_stall_stable got=%0d changes exp=0", unstable);
    end
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL rnd_err got=%b exp=0", err);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    sif.tvalid = 1'b0;
    sif.tlast  = 1'b0;
    sif.tdata  = '0;
    sif.tkeep  = '0;
    s_offset   = '0;
    mif.tready = 1'b1;
    @(negedge clk);
    test_reset();
    test_passthrough();
    test_short_tail();
    test_flush();
    test_error();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
